// File: rtl/uart_notify_pkg.sv
// rtl/uart_notify_pkg.sv - shared types, register bit positions and ASCII-hex decode for uart_notify_ctrl
package uart_notify_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_t;

    // STATUS register bit positions
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_ERR       = 3;
    localparam int ST_COUNT_LSB = 8;

    // CTRL register bit positions
    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_IRQ_EN  = 1;

    // One ASCII character to a hex nibble; bad=1 for anything outside 0-9, A-F, a-f.
    function automatic void hex_nibble(input logic [7:0] c, output logic [3:0] n, output logic bad);
        n   = 4'd0;
        bad = 1'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            n = c[3:0];
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 lands on 10..15
            n = 4'(c[3:0] + 4'd9);
        end else begin
            bad = 1'b1;
        end
    endfunction

endpackage

// File: rtl/notify_fifo.sv
// rtl/notify_fifo.sv - circular word FIFO with simultaneous push/pop
//
// Purpose: DEPTH-entry queue; head word is presented combinationally (0 when empty).
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   push, wdata      write request and word; accepted when not full or when popping
//   pop              read request; ignored when empty
//   rdata            head word, 0 when empty
//   full, empty      occupancy flags
//   count            number of stored words
module notify_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));
    assign count  = cnt;
    assign rdata  = empty ? '0 : mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_notify_ctrl.sv
// rtl/uart_notify_ctrl.sv - ASCII-hex payload decode, word queue and register/irq interface
//
// Purpose: decodes 8-char ASCII-hex payloads into 32-bit words, queues them and
//          exposes DATA/STATUS/CTRL registers with a level interrupt.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   drdy_tick       1-cycle pulse: ascii_in holds a complete payload
//   ascii_in[63:0]  8 ASCII chars, [63:56] most significant nibble
//   reg_sel[1:0]    0=DATA 1=STATUS 2=CTRL 3=reserved
//   reg_rd, reg_wr  1-cycle register strobes
//   reg_wdata[31:0] write data
//   reg_rdata[31:0] registered read data, held until the next read
//   irq             registered level interrupt
module uart_notify_ctrl
    import uart_notify_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        drdy_tick,
    input  logic [63:0] ascii_in,
    input  logic [1:0]  reg_sel,
    input  logic        reg_rd,
    input  logic        reg_wr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    reg_sel_t      sel;
    logic [31:0]   dec_word;
    logic          dec_bad;
    logic [3:0]    nib;
    logic          nib_bad;

    logic          stage_vld;
    logic [31:0]   stage_word;
    logic          stage_bad;

    logic          enable;
    logic          irq_en;
    logic          ovf;
    logic          err;

    logic          fifo_push;
    logic          fifo_pop;
    logic          pop_eff;
    logic [31:0]   fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          ovf_set;
    logic          err_set;
    logic          ovf_clr;
    logic          err_clr;
    logic          ctrl_wr;
    logic [31:0]   status_word;
    logic [31:0]   ctrl_word;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    assign sel          = reg_sel_t'(reg_sel);
    assign unused_wdata = ^reg_wdata[31:4];

    always_comb begin
        dec_word = '0;
        dec_bad  = 1'b0;
        nib      = '0;
        nib_bad  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            hex_nibble(ascii_in[8*i +: 8], nib, nib_bad);
            dec_word[4*i +: 4] = nib;
            dec_bad            = dec_bad | nib_bad;
        end
    end

    always_comb begin
        fifo_pop  = reg_rd & (sel == REG_DATA);
        pop_eff   = fifo_pop & ~fifo_empty;
        fifo_push = stage_vld & ~stage_bad;
        // Overflow only when no same-cycle pop makes room.
        ovf_set   = fifo_push & fifo_full & ~pop_eff;
        err_set   = stage_vld & stage_bad;
        ovf_clr   = reg_wr & (sel == REG_STATUS) & reg_wdata[ST_OVF];
        err_clr   = reg_wr & (sel == REG_STATUS) & reg_wdata[ST_ERR];
        ctrl_wr   = reg_wr & (sel == REG_CTRL);

        status_word                      = '0;
        status_word[ST_EMPTY]            = fifo_empty;
        status_word[ST_FULL]             = fifo_full;
        status_word[ST_OVF]              = ovf;
        status_word[ST_ERR]              = err;
        status_word[ST_COUNT_LSB +: 8]   = 8'(fifo_count);

        ctrl_word              = '0;
        ctrl_word[CTRL_ENABLE] = enable;
        ctrl_word[CTRL_IRQ_EN] = irq_en;

        case (sel)
            REG_DATA:   rd_mux = fifo_rdata;
            REG_STATUS: rd_mux = status_word;
            REG_CTRL:   rd_mux = ctrl_word;
            default:    rd_mux = '0;
        endcase
    end

    notify_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (stage_word),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_vld  <= 1'b0;
            stage_word <= '0;
            stage_bad  <= 1'b0;
            enable     <= 1'b1;
            irq_en     <= 1'b0;
            ovf        <= 1'b0;
            err        <= 1'b0;
            reg_rdata  <= '0;
            irq        <= 1'b0;
        end else begin
            stage_vld <= drdy_tick & enable;
            if (drdy_tick & enable) begin
                stage_word <= dec_word;
                stage_bad  <= dec_bad;
            end
            // Set wins over a same-cycle write-1-to-clear.
            ovf <= ovf_set | (ovf & ~ovf_clr);
            err <= err_set | (err & ~err_clr);
            if (ctrl_wr) begin
                enable <= reg_wdata[CTRL_ENABLE];
                irq_en <= reg_wdata[CTRL_IRQ_EN];
            end
            if (reg_rd) begin
                reg_rdata <= rd_mux;
            end
            irq <= irq_en & (~fifo_empty | ovf | err);
        end
    end

endmodule

// File: tb/tb_uart_notify_ctrl.sv
// tb/tb_uart_notify_ctrl.sv - self-checking bench for uart_notify_ctrl
module tb_uart_notify_ctrl;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        drdy_tick;
    logic [63:0] ascii_in;
    logic [1:0]  reg_sel;
    logic        reg_rd;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        irq;

    uart_notify_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .drdy_tick (drdy_tick),
        .ascii_in  (ascii_in),
        .reg_sel   (reg_sel),
        .reg_rd    (reg_rd),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ascii;
        logic [31:0] word;
        logic        bad;
    } vec_t;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];
    logic        model_ovf;
    logic        model_err;
    vec_t        vecs[10];
    logic [31:0] d;
    logic [31:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hex_ascii(input logic [31:0] w);
        logic [63:0] a;
        logic [3:0]  n;
        a = '0;
        for (int i = 0; i < 8; i++) begin
            n = w[4*i +: 4];
            a[8*i +: 8] = (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
        end
        return a;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (exp_q.size() == 0);
        s[1]     = (exp_q.size() == DEPTH);
        s[2]     = model_ovf;
        s[3]     = model_err;
        s[15:8]  = 8'(exp_q.size());
        return s;
    endfunction

    // Scoreboard update for a payload that reaches the stage.
    task automatic sb_payload(input logic [31:0] w, input logic bad);
        if (bad) model_err = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else model_ovf = 1'b1;
    endtask

    function automatic logic [31:0] sb_pop();
        if (exp_q.size() == 0) return 32'h0;
        return exp_q.pop_front();
    endfunction

    task automatic tick(input logic [63:0] a);
        ascii_in  = a;
        drdy_tick = 1'b1;
        @(negedge clk);
        drdy_tick = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] s, output logic [31:0] rd);
        reg_sel = s;
        reg_rd  = 1'b1;
        @(negedge clk);
        reg_rd  = 1'b0;
        rd      = reg_rdata;
    endtask

    task automatic reg_write(input logic [1:0] s, input logic [31:0] w);
        reg_sel   = s;
        reg_wdata = w;
        reg_wr    = 1'b1;
        @(negedge clk);
        reg_wr    = 1'b0;
    endtask

    task automatic check_status(input string name);
        logic [31:0] rd;
        reg_read(2'd1, rd);
        check(name, rd, exp_status());
    endtask

    task automatic check_data(input string name);
        logic [31:0] rd;
        reg_read(2'd0, rd);
        check(name, rd, sb_pop());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        model_ovf = 1'b0;
        model_err = 1'b0;
        reset     = 1'b1;
        drdy_tick = 1'b0;
        ascii_in  = '0;
        reg_sel   = '0;
        reg_rd    = 1'b0;
        reg_wr    = 1'b0;
        reg_wdata = '0;

        vecs[0] = '{"DEADBEEF", 32'hDEADBEEF, 1'b0};
        vecs[1] = '{"cafef00d", 32'hCAFEF00D, 1'b0};
        vecs[2] = '{"12G45678", 32'h0,        1'b1};
        vecs[3] = '{"00000000", 32'h00000000, 1'b0};
        vecs[4] = '{"FFFFFFFF", 32'hFFFFFFFF, 1'b0};
        vecs[5] = '{"0123abcd", 32'h0123ABCD, 1'b0};
        vecs[6] = '{"9aB8c7D6", 32'h9AB8C7D6, 1'b0};
        vecs[7] = '{"1234567:", 32'h0,        1'b1};
        vecs[8] = '{"@ABCDEF0", 32'h0,        1'b1};
        vecs[9] = '{"abcdefg0", 32'h0,        1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_rdata", reg_rdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check_status("reset_status");
        reg_read(2'd2, d);
        check("reset_ctrl", d, 32'h1);
        reg_read(2'd3, d);
        check("reserved_read", d, 32'h0);

        // Table-driven decode vectors
        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].ascii);
            sb_payload(vecs[i].word, vecs[i].bad);
            @(negedge clk);
            check_status($sformatf("vec%0d_status", i));
            if (vecs[i].bad) begin
                reg_write(2'd1, 32'h8);
                model_err = 1'b0;
            end else begin
                check_data($sformatf("vec%0d_data", i));
            end
        end
        check_status("vec_end_status");

        // Error interrupt and W1C
        reg_write(2'd2, 32'h3);
        tick("12G45678");
        sb_payload(32'h0, 1'b1);
        @(negedge clk);
        check("irq_before", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_err", {31'b0, irq}, 32'h1);
        check_status("err_status");
        reg_write(2'd1, 32'h8);
        model_err = 1'b0;
        @(negedge clk);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        check_status("err_cleared_status");

        // Non-empty FIFO also raises irq
        tick(hex_ascii(32'hA5A5_0001));
        sb_payload(32'hA5A5_0001, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_nonempty", {31'b0, irq}, 32'h1);
        check_data("irq_data");
        @(negedge clk);
        check("irq_drained", {31'b0, irq}, 32'h0);
        reg_write(2'd2, 32'h1);

        // Overflow: DEPTH+1 back-to-back payloads
        for (int k = 1; k <= DEPTH + 1; k++) begin
            tick(hex_ascii(32'(k)));
            sb_payload(32'(k), 1'b0);
        end
        @(negedge clk);
        check_status("ovf_status");
        for (int k = 0; k <= DEPTH; k++) begin
            check_data($sformatf("ovf_read%0d", k));
        end
        check_status("ovf_drained_status");
        reg_write(2'd1, 32'h4);
        model_ovf = 1'b0;
        check_status("ovf_cleared_status");

        // Full FIFO, DATA read in the same cycle as the stage push
        for (int k = 16; k < 16 + DEPTH; k++) begin
            tick(hex_ascii(32'(k)));
            sb_payload(32'(k), 1'b0);
        end
        @(negedge clk);
        tick(hex_ascii(32'h14));
        reg_read(2'd0, d);
        e = sb_pop();
        sb_payload(32'h14, 1'b0);
        check("fullpop_data", d, e);
        check_status("fullpop_status");
        for (int k = 0; k < DEPTH; k++) begin
            check_data($sformatf("fullpop_read%0d", k));
        end

        // Empty FIFO, DATA read in the same cycle as the stage push
        tick("00c0ffee");
        reg_read(2'd0, d);
        e = sb_pop();
        sb_payload(32'h00C0FFEE, 1'b0);
        check("emptypop_data", d, e);
        check_status("emptypop_status");
        check_data("emptypop_read");

        // enable=0 ignores new payloads but lets an in-flight stage word land
        tick(hex_ascii(32'h0000BEAD));
        reg_write(2'd2, 32'h0);
        sb_payload(32'h0000BEAD, 1'b0);
        tick("11111111");
        @(negedge clk);
        check_status("disabled_status");
        check_data("disabled_inflight_data");
        reg_read(2'd2, d);
        check("disabled_ctrl", d, 32'h0);

        // Asynchronous reset with a word in the stage
        reg_write(2'd2, 32'h3);
        tick(hex_ascii(32'h77));
        sb_payload(32'h77, 1'b0);
        @(negedge clk);
        reg_read(2'd1, d);
        check("prereset_irq", {31'b0, irq}, 32'h1);
        ascii_in  = hex_ascii(32'h88);
        drdy_tick = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_rdata", reg_rdata, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        drdy_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
        model_err = 1'b0;
        repeat (2) @(negedge clk);
        check("postreset_irq", {31'b0, irq}, 32'h0);
        reg_read(2'd2, d);
        check("postreset_ctrl", d, 32'h1);
        check_status("postreset_status");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
